router_port_ingress: RTL and testbench



---
 rtl/router_port_ingress.sv | 149 ++++++++++++++
 tb/tb_router_port_ingress.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_port_ingress.sv
// router_port_ingress
//   Receive side of one router link. Flits arriving from the upstream router
//   are sorted into one FIFO per virtual channel (VC index = low flit bits).
//   Returning credits go into one credit FIFO. The local router drains both
//   through valid/ack handshakes. The link has no backpressure, so an
//   overflow or a bad VC index drops the item and raises a sticky error.
//
// Ports
//   clock, reset        system clock, async active-high reset
//   enable              gates all router-side reads (acks ignored when low)
//   link_flit[_valid]   flit from upstream, written regardless of enable
//   link_credit[_valid] credit from downstream, written regardless of enable
//   flit_out[v]         head flit of VC v (0 when empty)
//   flit_out_valid[v]   VC v non-empty
//   flit_ack[v]         router consumed head of VC v
//   credit_out[_valid]  head of credit FIFO (0 when empty)
//   credit_ack          router consumed head credit
//   vc_occupancy[v]     entry count of VC v
//   is_quiescent        every FIFO empty
//   error               sticky overflow / bad-VC flag

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef CREDIT_WIDTH
`define CREDIT_WIDTH 8
`endif

// Single-write-port FIFO with asynchronous head read and no bypass.
module router_port_fifo #(
  parameter int W     = 8,
  parameter int LOG_D = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic             valid,
  output logic [LOG_D:0]   count,
  output logic             overflow
);
  localparam int DEPTH = 1 << LOG_D;

  logic [W-1:0]     mem [DEPTH];
  logic [LOG_D-1:0] rd_ptr, wr_ptr;
  logic             full, rd, wr;

  // count never exceeds DEPTH, so its MSB alone means full
  assign valid    = |count;
  assign full     = count[LOG_D];
  assign rd       = rd_en & valid;
  // a same-cycle read frees the slot, so a write into a full FIFO is legal
  assign wr       = wr_en & (~full | rd);
  assign overflow = wr_en & full & ~rd;
  assign rd_data  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clock)
    if (wr) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + LOG_D'(1);
      if (rd) rd_ptr <= rd_ptr + LOG_D'(1);
      if (wr && !rd)      count <= count + (LOG_D+1)'(1);
      else if (rd && !wr) count <= count - (LOG_D+1)'(1);
    end
  end
endmodule

module router_port_ingress #(
  parameter int NVCS     = 2,
  parameter int LOG_DEP  = 4,
  parameter int LOG_CDEP = 3
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [`FLIT_WIDTH-1:0]              link_flit,
  input  logic                                link_flit_valid,
  input  logic [`CREDIT_WIDTH-1:0]            link_credit,
  input  logic                                link_credit_valid,
  output logic [NVCS-1:0][`FLIT_WIDTH-1:0]    flit_out,
  output logic [NVCS-1:0]                     flit_out_valid,
  input  logic [NVCS-1:0]                     flit_ack,
  output logic [`CREDIT_WIDTH-1:0]            credit_out,
  output logic                                credit_out_valid,
  input  logic                                credit_ack,
  output logic [NVCS-1:0][LOG_DEP:0]          vc_occupancy,
  output logic                                is_quiescent,
  output logic                                error
);
  localparam int LOG_NVCS = (NVCS > 1) ? $clog2(NVCS) : 1;

  logic [LOG_NVCS-1:0] vc_idx;
  logic [NVCS-1:0]     vc_ovf;
  logic                cr_ovf, bad_vc;
  logic [LOG_CDEP:0]   cr_count;

  assign vc_idx = link_flit[LOG_NVCS-1:0];

  // indices past NVCS only exist when NVCS is not a power of two
  generate
    if ((1 << LOG_NVCS) != NVCS) begin : g_badvc
      assign bad_vc = link_flit_valid && (int'(vc_idx) >= NVCS);
    end else begin : g_nobadvc
      assign bad_vc = 1'b0;
    end
  endgenerate

  for (genvar v = 0; v < NVCS; v++) begin : g_vc
    router_port_fifo #(.W(`FLIT_WIDTH), .LOG_D(LOG_DEP)) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (link_flit_valid && (vc_idx == LOG_NVCS'(v))),
      .wr_data  (link_flit),
      .rd_en    (enable & flit_ack[v]),
      .rd_data  (flit_out[v]),
      .valid    (flit_out_valid[v]),
      .count    (vc_occupancy[v]),
      .overflow (vc_ovf[v])
    );
  end

  router_port_fifo #(.W(`CREDIT_WIDTH), .LOG_D(LOG_CDEP)) u_credit (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (link_credit_valid),
    .wr_data  (link_credit),
    .rd_en    (enable & credit_ack),
    .rd_data  (credit_out),
    .valid    (credit_out_valid),
    .count    (cr_count),
    .overflow (cr_ovf)
  );

  // valid flags derive from registered counts only
  assign is_quiescent = ~(|flit_out_valid) & ~credit_out_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) error <= 1'b0;
    else if (bad_vc || (|vc_ovf) || cr_ovf) error <= 1'b1;
  end
endmodule

// File: tb/tb_router_port_ingress.sv
module tb_router_port_ingress;
  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic [15:0]      link_flit = '0;
  logic             link_flit_valid = 1'b0;
  logic [7:0]       link_credit = '0;
  logic             link_credit_valid = 1'b0;
  logic [1:0][15:0] flit_out;
  logic [1:0]       flit_out_valid;
  logic [1:0]       flit_ack = '0;
  logic [7:0]       credit_out;
  logic             credit_out_valid;
  logic             credit_ack = 1'b0;
  logic [1:0][4:0]  vc_occupancy;
  logic             is_quiescent;
  logic             error;

  int checks = 0;
  int failures = 0;

  router_port_ingress dut (
    .clock(clock), .reset(reset), .enable(enable),
    .link_flit(link_flit), .link_flit_valid(link_flit_valid),
    .link_credit(link_credit), .link_credit_valid(link_credit_valid),
    .flit_out(flit_out), .flit_out_valid(flit_out_valid), .flit_ack(flit_ack),
    .credit_out(credit_out), .credit_out_valid(credit_out_valid),
    .credit_ack(credit_ack), .vc_occupancy(vc_occupancy),
    .is_quiescent(is_quiescent), .error(error)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: plain queues, 16 deep per VC, 8 deep for credits.
  logic [15:0] mq [2][$];
  logic [7:0]  cq [$];
  logic        merr = 1'b0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < 2; v++) mq[v].delete();
      cq.delete();
      merr = 1'b0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (enable && flit_ack[v] && mq[v].size() > 0) void'(mq[v].pop_front());
        if (link_flit_valid && int'(link_flit[0]) == v) begin
          if (mq[v].size() < 16) mq[v].push_back(link_flit);
          else merr = 1'b1;
        end
      end
      if (enable && credit_ack && cq.size() > 0) void'(cq.pop_front());
      if (link_credit_valid) begin
        if (cq.size() < 8) cq.push_back(link_credit);
        else merr = 1'b1;
      end
    end
  end

  task automatic check_all(input string tag);
    logic [15:0] eh;
    logic [7:0]  ec;
    for (int v = 0; v < 2; v++) begin
      eh = (mq[v].size() > 0) ? mq[v][0] : 16'h0;
      chk($sformatf("%s_valid%0d", tag, v), 64'(flit_out_valid[v]), 64'(mq[v].size() > 0));
      chk($sformatf("%s_head%0d", tag, v), 64'(flit_out[v]), 64'(eh));
      chk($sformatf("%s_occ%0d", tag, v), 64'(vc_occupancy[v]), 64'(mq[v].size()));
    end
    ec = (cq.size() > 0) ? cq[0] : 8'h0;
    chk({tag, "_cvalid"}, 64'(credit_out_valid), 64'(cq.size() > 0));
    chk({tag, "_chead"}, 64'(credit_out), 64'(ec));
    chk({tag, "_quiet"}, 64'(is_quiescent),
        64'(mq[0].size() == 0 && mq[1].size() == 0 && cq.size() == 0));
    chk({tag, "_error"}, 64'(error), 64'(merr));
  endtask

  always @(negedge clock) if (!reset) check_all("cyc");

  // Order monitor for the wrap test: k-th flit on VC v must be 2k+v.
  logic mon_en = 1'b0;
  int   del_cnt [2] = '{0, 0};
  int   ord_bad = 0;
  always @(negedge clock) begin
    if (mon_en && !reset)
      for (int v = 0; v < 2; v++)
        if (enable && flit_ack[v] && flit_out_valid[v]) begin
          if (flit_out[v] !== 16'(2 * del_cnt[v] + v)) ord_bad++;
          del_cnt[v]++;
        end
  end

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic idle_in;
    link_flit_valid = 1'b0; link_credit_valid = 1'b0;
    flit_ack = '0; credit_ack = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1; idle_in(); enable = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    // reset and single flit
    do_reset();
    chk("rst_valid", 64'(flit_out_valid), 64'h0);
    chk("rst_head1", 64'(flit_out[1]), 64'h0);
    chk("rst_occ", 64'(vc_occupancy), 64'h0);
    chk("rst_quiet", 64'(is_quiescent), 64'h1);
    chk("rst_error", 64'(error), 64'h0);
    chk("rst_cvalid", 64'(credit_out_valid), 64'h0);
    link_flit = 16'hA5A1; link_flit_valid = 1'b1;
    tick();
    link_flit_valid = 1'b0;
    chk("t1_valid", 64'(flit_out_valid), 64'h2);
    chk("t1_head", 64'(flit_out[1]), 64'hA5A1);
    chk("t1_occ", 64'(vc_occupancy[1]), 64'h1);
    chk("t1_quiet", 64'(is_quiescent), 64'h0);
    enable = 1'b1; flit_ack = 2'b10;
    tick();
    flit_ack = 2'b00;
    chk("t1_drained", 64'(flit_out_valid), 64'h0);
    chk("t1_quiet2", 64'(is_quiescent), 64'h1);

    // ordering and wrap: 40 flits alternating VCs, acked every cycle
    do_reset();
    enable = 1'b1; flit_ack = 2'b11; mon_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      link_flit = 16'(i); link_flit_valid = 1'b1;
      tick();
    end
    link_flit_valid = 1'b0;
    tick(); tick(); tick();
    mon_en = 1'b0; flit_ack = 2'b00;
    chk("t2_cnt0", 64'(del_cnt[0]), 64'd20);
    chk("t2_cnt1", 64'(del_cnt[1]), 64'd20);
    chk("t2_order", 64'(ord_bad), 64'd0);
    chk("t2_error", 64'(error), 64'h0);

    // full boundary
    do_reset();
    for (int i = 0; i < 16; i++) begin
      link_flit = 16'(i << 1); link_flit_valid = 1'b1;
      tick();
    end
    link_flit_valid = 1'b0;
    chk("t3_occ16", 64'(vc_occupancy[0]), 64'd16);
    chk("t3_noerr", 64'(error), 64'h0);
    link_flit = 16'h0100; link_flit_valid = 1'b1;
    tick();
    link_flit_valid = 1'b0;
    chk("t3_ovf_err", 64'(error), 64'h1);
    chk("t3_ovf_occ", 64'(vc_occupancy[0]), 64'd16);
    tick(); tick();
    chk("t3_sticky", 64'(error), 64'h1);
    do_reset();
    for (int i = 0; i < 16; i++) begin
      link_flit = 16'(i << 1); link_flit_valid = 1'b1;
      tick();
    end
    link_flit = 16'h0100; enable = 1'b1; flit_ack = 2'b01;
    tick();
    idle_in();
    chk("t3_rw_err", 64'(error), 64'h0);
    chk("t3_rw_occ", 64'(vc_occupancy[0]), 64'd16);
    chk("t3_rw_head", 64'(flit_out[0]), 64'h2);

    // enable gating
    do_reset();
    enable = 1'b0; flit_ack = 2'b11;
    for (int c = 0; c < 5; c++) begin
      link_flit = 16'h0200 + 16'(c * 2); link_flit_valid = (c < 3);
      tick();
    end
    link_flit_valid = 1'b0;
    chk("t4_held", 64'(vc_occupancy[0]), 64'd3);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t4_head%0d", k), 64'(flit_out[0]), 64'h0200 + 64'(k * 2));
      tick();
      chk($sformatf("t4_occ%0d", k), 64'(vc_occupancy[0]), 64'(2 - k));
    end
    flit_ack = 2'b00;

    // credits
    do_reset();
    for (int i = 0; i < 8; i++) begin
      link_credit = 8'h10 + 8'(i); link_credit_valid = 1'b1;
      tick();
    end
    link_credit_valid = 1'b0;
    chk("t5_cvalid", 64'(credit_out_valid), 64'h1);
    chk("t5_chead", 64'(credit_out), 64'h10);
    chk("t5_noerr", 64'(error), 64'h0);
    link_credit = 8'hFF; link_credit_valid = 1'b1;
    tick();
    link_credit_valid = 1'b0;
    chk("t5_ovf", 64'(error), 64'h1);
    enable = 1'b1; credit_ack = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t5_drain%0d", k), 64'(credit_out), 64'h10 + 64'(k));
      tick();
    end
    credit_ack = 1'b0;
    chk("t5_empty", 64'(credit_out_valid), 64'h0);

    // async reset mid-burst
    do_reset();
    for (int i = 0; i < 5; i++) begin
      link_flit = 16'h0300 + 16'(i); link_flit_valid = 1'b1;
      tick();
    end
    link_flit_valid = 1'b0;
    chk("t6_occ0", 64'(vc_occupancy[0]), 64'd3);
    chk("t6_occ1", 64'(vc_occupancy[1]), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", 64'(flit_out_valid), 64'h0);
    chk("t6_occ", 64'(vc_occupancy), 64'h0);
    chk("t6_error", 64'(error), 64'h0);
    chk("t6_quiet", 64'(is_quiescent), 64'h1);
    check_all("t6");
    tick();
    reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
